// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter device.
//   - tx_state_e   : transmitter frame state encoding
//   - UART_*       : register offsets decoded from Addr[3:2]
//   - CTRL_* / STAT_* : bit positions inside CTRL and STATUS
//   - parity_even  : even-parity bit for one data byte
//   - eff_div      : divisor clamp (0 behaves as 1)
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] UART_DATA   = 2'd0;
   localparam logic [1:0] UART_CTRL   = 2'd1;
   localparam logic [1:0] UART_STATUS = 2'd2;
   localparam logic [1:0] UART_DIV    = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_IE_BIT   = 1;
   localparam int CTRL_PODD_BIT = 2;

   localparam int STAT_BUSY_BIT = 4;
   localparam int STAT_OVF_BIT  = 5;
   localparam int STAT_IRQ_BIT  = 6;

   // Even parity: the extra bit that makes the total number of ones even.
   function automatic logic parity_even(input logic [7:0] b);
      return ^b;
   endfunction

   // A programmed divisor of zero would never produce a bit boundary.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk, reset (sync, active-low)
//   push/din  : write one byte (caller guarantees room, or a pop in the same cycle)
//   pop/dout  : dout shows the head entry; pop advances past it
//   count     : number of stored entries
//   full/empty: occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] PTR_ONE = 1;

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q;
   logic [AW:0] rptr_q;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count = wptr_q - rptr_q;
   assign dout  = mem_q[rptr_q[AW-1:0]];

   // Storage and pointer update; a push and a pop may occur together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
      end else begin
         if (push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
            wptr_q                <= wptr_q + PTR_ONE;
         end
         if (pop) begin
            rptr_q <= rptr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped UART transmitter on the bridge device bus.
// Ports:
//   clk, reset (sync, active-low)
//   Addr[3:2] selects DATA/CTRL/STATUS/DIV; WE strobes a write of Din
//   Dout : combinational read data for the selected register
//   IRQ  : level interrupt (pending & IE)
//   txd  : serial output, idle high
// Optional build macro UART_TX_PARITY_EN adds a parity bit after the data
// bits, with CTRL bit2 selecting odd (1) or even (0) parity.
module uart_tx_dev
   import uart_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        txd
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Register file
   logic        en_q, ie_q, ovf_q, pend_q;
   logic [15:0] div_q;
`ifdef UART_TX_PARITY_EN
   logic        podd_q;
   logic        par_q, par_d;
`endif

   // Transmit engine
   tx_state_e   state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] fdiv_q, fdiv_d;
   logic        txd_q, txd_d;

   logic        wr_data_s, wr_ctrl_s, wr_stat_s, wr_div_s;
   logic        push_s, pop_s, ovf_set_s, pend_set_s, load_s, bit_done_s, busy_s;
   logic [7:0]  fifo_dout_s;
   logic [AW:0] fifo_count_s;
   logic        full_s, empty_s;
   logic        unused_s;

   assign unused_s  = ^{Addr[31:4], Addr[1:0], Din[31:16]};

   assign wr_data_s = WE && (Addr[3:2] == UART_DATA);
   assign wr_ctrl_s = WE && (Addr[3:2] == UART_CTRL);
   assign wr_stat_s = WE && (Addr[3:2] == UART_STATUS);
   assign wr_div_s  = WE && (Addr[3:2] == UART_DIV);

   // A pop in the same cycle frees the slot, so a write into a full FIFO then lands.
   assign push_s     = wr_data_s && (!full_s || pop_s);
   assign ovf_set_s  = wr_data_s && full_s && !pop_s;
   assign bit_done_s = (cnt_q == (fdiv_q - 16'd1));
   assign busy_s     = (state_q != ST_IDLE);

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (Din[7:0]),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Software-visible control and sticky status registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         en_q   <= 1'b0;
         ie_q   <= 1'b0;
         div_q  <= DIV_RESET;
         ovf_q  <= 1'b0;
         pend_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         podd_q <= 1'b0;
`endif
      end else begin
         if (wr_ctrl_s) begin
            en_q   <= Din[CTRL_EN_BIT];
            ie_q   <= Din[CTRL_IE_BIT];
`ifdef UART_TX_PARITY_EN
            podd_q <= Din[CTRL_PODD_BIT];
`endif
         end
         if (wr_div_s) begin
            div_q <= Din[15:0];
         end
         if (ovf_set_s) begin
            ovf_q <= 1'b1;
         end else if (wr_stat_s) begin
            ovf_q <= 1'b0;
         end
         // Setting has priority over a clearing STATUS write in the same cycle.
         if (pend_set_s) begin
            pend_q <= 1'b1;
         end else if (wr_stat_s) begin
            pend_q <= 1'b0;
         end
      end
   end

   // FSM state register together with the frame datapath it steers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shift_q <= 8'd0;
         idx_q   <= 3'd0;
         cnt_q   <= 16'd0;
         fdiv_q  <= eff_div(DIV_RESET);
         txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         fdiv_q  <= fdiv_d;
         txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state logic: bit timer, frame sequencing and head-byte loading.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      fdiv_d  = fdiv_q;
      load_s  = 1'b0;
      pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if ((state_q == ST_IDLE) || bit_done_s) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
      case (state_q)
         ST_IDLE: begin
            load_s = en_q && !empty_s;
         end
         ST_START: begin
            if (bit_done_s) begin
               state_d = ST_DATA;
               idx_d   = 3'd0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_done_s) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_done_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (bit_done_s) begin
               load_s  = en_q && !empty_s;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Starting a frame pops the head byte and freezes the divisor for the frame.
      if (load_s) begin
         state_d = ST_START;
         shift_d = fifo_dout_s;
         fdiv_d  = eff_div(div_q);
         pop_s   = 1'b1;
`ifdef UART_TX_PARITY_EN
         par_d   = parity_even(fifo_dout_s) ^ podd_q;
`endif
      end else begin
         fdiv_d = fdiv_q;
      end
   end

   // Output logic: line level for the upcoming state, and the drain interrupt event.
   always_comb begin
      pend_set_s = (state_q == ST_STOP) && bit_done_s && empty_s;
      case (state_d)
         ST_IDLE:   txd_d = 1'b1;
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_d = par_d;
`else
         ST_PARITY: txd_d = 1'b1;
`endif
         ST_STOP:   txd_d = 1'b1;
         default:   txd_d = 1'b1;
      endcase
   end

   // Register read mux.
   always_comb begin
      Dout = 32'd0;
      case (Addr[3:2])
         UART_DATA: Dout = 32'd0;
         UART_CTRL: begin
            Dout[CTRL_EN_BIT]   = en_q;
            Dout[CTRL_IE_BIT]   = ie_q;
`ifdef UART_TX_PARITY_EN
            Dout[CTRL_PODD_BIT] = podd_q;
`endif
         end
         UART_STATUS: begin
            Dout[3:0]           = 4'(fifo_count_s);
            Dout[STAT_BUSY_BIT] = busy_s;
            Dout[STAT_OVF_BIT]  = ovf_q;
            Dout[STAT_IRQ_BIT]  = pend_q;
         end
         UART_DIV: Dout = {16'd0, div_q};
         default:  Dout = 32'd0;
      endcase
   end

   assign IRQ = pend_q & ie_q;
   assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev.
module tb_uart_tx_dev;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [31:0] CTRL_B2_RB = 32'd4;
`else
   localparam int NB = 10;
   localparam logic [31:0] CTRL_B2_RB = 32'd0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        txd;

   int pass_cnt  = 0;
   int total_cnt = 0;

   uart_tx_dev dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .txd   (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the write edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      Addr = a;
      @(negedge clk);
      chk(tag, Dout, exp);
      @(posedge clk);
      #1;
   endtask

   // Starts at a falling edge; checks idle gap then every cycle of one frame.
   task automatic frame(input string tag, input logic [7:0] b, input int div, input int gap,
                        input logic par, input logic mid, input logic [31:0] ma,
                        input logic [31:0] md, input int mat);
      logic [10:0] bits;
      int n;
      bits       = 11'h7FF;
      bits[0]    = 1'b0;
      bits[8:1]  = b;
      if (NB == 11) bits[9] = par;
      n = 0;
      while (txd !== 1'b0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_gap"}, 32'(n), 32'(gap));
      for (int k = 0; k < NB * div; k++) begin
         if (mid && k == mat) begin
            Addr = ma;
            Din  = md;
            WE   = 1'b1;
         end else if (mid && k == mat + 1) begin
            WE   = 1'b0;
         end
         chk($sformatf("%s_c%0d", tag, k), {31'd0, txd}, {31'd0, bits[k / div]});
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      WE    = 1'b0;
      Addr  = 32'd0;
      Din   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset restores DIV after it was reprogrammed
      bus_write(32'd12, 32'd2);
      read_check("div_wr", 32'd12, 32'd2);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_irq", {31'd0, IRQ}, 32'd0);
      read_check("rst_status", 32'd8, 32'd0);
      read_check("rst_div", 32'd12, 32'd434);
      read_check("rst_ctrl", 32'd4, 32'd0);

      // Single byte 0xA5 at DIV=2
      bus_write(32'd12, 32'd2);
      bus_write(32'd4, 32'd3);
      bus_write(32'd0, 32'hA5);
      @(negedge clk);
      frame("a5", 8'hA5, 2, 1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      chk("a5_irq", {31'd0, IRQ}, 32'd1);
      @(posedge clk);
      #1;
      read_check("a5_status", 32'd8, 32'h40);
      bus_write(32'd8, 32'd0);
      read_check("a5_clr", 32'd8, 32'd0);
      chk("a5_irq_clr", {31'd0, IRQ}, 32'd0);

      // Overflow, then four back-to-back frames; DIV 2->4 during frame 1
      bus_write(32'd4, 32'd2);
      bus_write(32'd0, 32'h11);
      bus_write(32'd0, 32'h22);
      bus_write(32'd0, 32'h33);
      bus_write(32'd0, 32'h44);
      bus_write(32'd0, 32'h55);
      read_check("ovf_status", 32'd8, 32'h24);
      bus_write(32'd4, 32'd3);
      @(negedge clk);
      frame("f1", 8'h11, 2, 1, 1'b0, 1'b1, 32'd12, 32'd4, 5);
      frame("f2", 8'h22, 4, 0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      frame("f3", 8'h33, 4, 0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      frame("f4", 8'h44, 4, 0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      chk("f4_irq", {31'd0, IRQ}, 32'd1);
      @(posedge clk);
      #1;
      read_check("f4_status", 32'd8, 32'h60);

      // EN cleared mid-frame: frame completes, queued byte stays
      bus_write(32'd4, 32'd2);
      bus_write(32'd0, 32'h3C);
      bus_write(32'd0, 32'hC3);
      bus_write(32'd8, 32'd0);
      bus_write(32'd12, 32'd2);
      bus_write(32'd4, 32'd3);
      @(negedge clk);
      frame("en", 8'h3C, 2, 1, 1'b0, 1'b1, 32'd4, 32'd2, 6);
      for (int i = 0; i < 30; i++) begin
         chk($sformatf("en_idle%0d", i), {31'd0, txd}, 32'd1);
         @(negedge clk);
      end
      chk("en_irq", {31'd0, IRQ}, 32'd0);
      @(posedge clk);
      #1;
      read_check("en_status", 32'd8, 32'h01);

      // Reset during data bit 3 of 0xC3
      bus_write(32'd0, 32'h5A);
      bus_write(32'd4, 32'd3);
      Addr = 32'd8;
      repeat (10) @(negedge clk);
      chk("mr_bit3", {31'd0, txd}, 32'd0);
      chk("mr_busy", Dout, 32'h11);
      reset = 1'b0;
      @(negedge clk);
      chk("mr_txd", {31'd0, txd}, 32'd1);
      chk("mr_status", Dout, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      read_check("mr_div", 32'd12, 32'd434);
      read_check("mr_ctrl", 32'd4, 32'd0);
      repeat (5) @(negedge clk);
      chk("mr_idle", {31'd0, txd}, 32'd1);
      @(posedge clk);
      #1;

      // CTRL bit2 and parity frames (0x07: even -> 1, odd -> 0)
      bus_write(32'd12, 32'd2);
      bus_write(32'd4, 32'd4);
      read_check("ctrl_b2", 32'd4, CTRL_B2_RB);
      bus_write(32'd4, 32'd3);
      bus_write(32'd0, 32'h07);
      @(negedge clk);
      frame("pe", 8'h07, 2, 1, 1'b1, 1'b0, 32'd0, 32'd0, 0);
      @(posedge clk);
      #1;
      bus_write(32'd4, 32'd7);
      bus_write(32'd0, 32'h07);
      @(negedge clk);
      frame("po", 8'h07, 2, 1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      chk("po_irq", {31'd0, IRQ}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
